// File: rtl/medidor_ciclo_trabajo.sv
// medidor_ciclo_trabajo: measures duty (in slots of DIV cycles) and period of a 16-slot PWM input, flags bad period and lost signal; `PWM_DEGLITCH_EN adds a 3-cycle stability filter
module medidor_ciclo_trabajo #(
  parameter int DIV = 100,
  parameter int TIMEOUT_PERIODOS = 2
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       enable,
  input  logic       pwm_in,
  output logic [3:0] duty_medido,
  output logic       duty_valido,
  output logic       periodo_err,
  output logic       sin_senal
);
  localparam int TO_MAX = TIMEOUT_PERIODOS * 16 * DIV;
  localparam int PER_MIN = 16 * DIV - DIV / 2;
  localparam int PER_MAX = 16 * DIV + DIV / 2;
  localparam int CW = $clog2(TO_MAX + 1);
  localparam int CPW = $clog2(PER_MAX + 2);
  localparam int PW = $clog2(DIV);
  localparam int PSC0 = DIV / 2 + 1;
  localparam logic [PW-1:0] PSC_INI = (PSC0 >= DIV) ? '0 : PW'(PSC0);
  localparam logic [3:0] SL_INI = (PSC0 >= DIV) ? 4'd1 : 4'd0;
  typedef enum logic [1:0] {ESPERA, ALTO, BAJO} est_e;
  est_e est_q, est_d;
  logic s1_q, s2_q, s3_q, lvl, rise, fall, pub, tmo, cuenta;
  logic [CW-1:0] cnt_to_q, cnt_to_d;
  logic [CPW-1:0] cnt_per_q, cnt_per_d;
  logic [PW-1:0] psc_q, psc_d;
  logic [3:0] sl_q, sl_d, duty_q, duty_d;
  logic err_q, err_d, val_q, val_d, sin_q, sin_d;
  // two-flop synchronizer for the asynchronous PWM line
  always_ff @(posedge clk_100MHz) begin
    if (rst) {s1_q, s2_q} <= '0;
    else {s1_q, s2_q} <= {pwm_in, s1_q};
  end
`ifdef PWM_DEGLITCH_EN
  logic flt_q;
  logic [1:0] cnt_f_q;
  // filtered level follows s2 only after it has differed for 3 consecutive cycles
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      flt_q <= 1'b0;
      cnt_f_q <= '0;
    end else if (s2_q == flt_q) cnt_f_q <= '0;
    else if (cnt_f_q == 2'd2) begin
      flt_q <= s2_q;
      cnt_f_q <= '0;
    end else cnt_f_q <= cnt_f_q + 2'd1;
  end
  assign lvl = flt_q;
`else
  assign lvl = s2_q;
`endif
  // delayed copy of the edge-detection level
  always_ff @(posedge clk_100MHz) begin
    if (rst) s3_q <= 1'b0;
    else s3_q <= lvl;
  end
  assign rise = lvl & ~s3_q;
  assign fall = ~lvl & s3_q;
  assign pub = enable && rise && est_q == BAJO;
  assign tmo = enable && !rise && cnt_to_q == CW'(TO_MAX - 1);
  assign cuenta = est_q == ALTO && !fall;
  // state register
  always_ff @(posedge clk_100MHz) begin
    if (rst) est_q <= ESPERA;
    else est_q <= est_d;
  end
  // next state: a rise always wins over a timeout hitting in the same cycle
  always_comb begin
    est_d = !enable ? ESPERA : rise ? ALTO : tmo ? ESPERA : (est_q == ALTO && fall) ? BAJO : est_q;
  end
  // counters and published results; a rise restarts everything in the same cycle
  always_comb begin
    cnt_to_d = !enable ? '0 : rise ? CW'(1) : (cnt_to_q == CW'(TO_MAX)) ? cnt_to_q : cnt_to_q + CW'(1);
    cnt_per_d = !enable ? '0 : rise ? CPW'(1) : (est_q == ESPERA) ? '0 :
                (cnt_per_q == CPW'(PER_MAX + 1)) ? cnt_per_q : cnt_per_q + CPW'(1);
    psc_d = !enable ? '0 : rise ? PSC_INI : !cuenta ? psc_q : (psc_q == PW'(DIV - 1)) ? '0 : psc_q + PW'(1);
    sl_d = !enable ? '0 : rise ? SL_INI :
           (cuenta && psc_q == PW'(DIV - 1) && sl_q != 4'hf) ? sl_q + 4'd1 : sl_q;
    duty_d = pub ? sl_q : tmo ? {4{s2_q}} : duty_q;
    err_d = pub ? !(cnt_per_q >= CPW'(PER_MIN) && cnt_per_q <= CPW'(PER_MAX)) : tmo ? 1'b1 : err_q;
    sin_d = (enable && rise) ? 1'b0 : tmo ? 1'b1 : sin_q;
    val_d = pub | tmo;
  end
  // datapath and output registers
  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      cnt_to_q <= '0;
      cnt_per_q <= '0;
      psc_q <= '0;
      sl_q <= '0;
      duty_q <= '0;
      err_q <= 1'b0;
      val_q <= 1'b0;
      sin_q <= 1'b0;
    end else begin
      cnt_to_q <= cnt_to_d;
      cnt_per_q <= cnt_per_d;
      psc_q <= psc_d;
      sl_q <= sl_d;
      duty_q <= duty_d;
      err_q <= err_d;
      val_q <= val_d;
      sin_q <= sin_d;
    end
  end
  assign duty_medido = duty_q;
  assign duty_valido = val_q;
  assign periodo_err = err_q;
  assign sin_senal = sin_q;
endmodule

// File: tb/tb_medidor_ciclo_trabajo.sv
// tb_medidor_ciclo_trabajo: randomized and directed bench for the duty-cycle meter (default build, no deglitch filter)
module tb_medidor_ciclo_trabajo;
  localparam int DIV = 4;
  localparam int TP = 2;
  localparam int LAT = 3;
  logic clk, rst, enable, pwm;
  logic [3:0] duty;
  logic val, err, sin;
  int n_run, n_fail, cyc;
  logic [3:0] qd[$], xd[$];
  logic qe[$], qs[$], xe[$], xs[$];
  int qc[$];

  medidor_ciclo_trabajo #(.DIV(DIV), .TIMEOUT_PERIODOS(TP)) dut (
    .clk_100MHz(clk), .rst(rst), .enable(enable), .pwm_in(pwm),
    .duty_medido(duty), .duty_valido(val), .periodo_err(err), .sin_senal(sin));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (val === 1'b1) begin
      qd.push_back(duty);
      qe.push_back(err);
      qs.push_back(sin);
      qc.push_back(cyc);
    end
  end

  function automatic logic [3:0] slots(int h);
    int s;
    s = (h + DIV / 2) / DIV;
    return s > 15 ? 4'd15 : 4'(s);
  endfunction
  function automatic logic bad(int p);
    return p < 16 * DIV - DIV / 2 || p > 16 * DIV + DIV / 2;
  endfunction
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic period(int h, int p);
    pwm = 1'b1;
    tick(h);
    pwm = 1'b0;
    tick(p - h);
  endtask
  task automatic expect_pulse(logic [3:0] d, logic e, logic s);
    xd.push_back(d);
    xe.push_back(e);
    xs.push_back(s);
  endtask
  task automatic expect_per(int h, int p);
    expect_pulse(slots(h), bad(p), 1'b0);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    enable = 1'b1;
    pwm = 1'b0;
    tick(3);
    rst = 1'b0;
    qd.delete(); qe.delete(); qs.delete(); qc.delete();
    xd.delete(); xe.delete(); xs.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_run += 4;
    if (duty !== 4'd0) begin n_fail++; $display("FAIL reset duty: got %0d want 0", duty); end
    if (val !== 1'b0) begin n_fail++; $display("FAIL reset valido: got %b want 0", val); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset err: got %b want 0", err); end
    if (sin !== 1'b0) begin n_fail++; $display("FAIL reset sin: got %b want 0", sin); end
  endtask

  task automatic test_directed;
    int hs[8] = '{20, 20, 21, 22, 63, 20, 20, 20};
    int ps[8] = '{64, 64, 64, 64, 66, 70, 66, 127};
    int t0;
    do_reset;
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) t0 = cyc;
      period(hs[i], ps[i]);
      expect_per(hs[i], ps[i]);
    end
    pwm = 1'b1;
    tick(LAT + 3);
    n_run++;
    if (qd.size() != xd.size()) begin n_fail++; $display("FAIL directed count: got %0d want %0d", qd.size(), xd.size()); end
    for (int i = 0; i < xd.size() && i < qd.size(); i++) begin
      n_run++;
      if (qd[i] !== xd[i] || qe[i] !== xe[i] || qs[i] !== xs[i]) begin
        n_fail++;
        $display("FAIL directed pulse %0d: got d=%0d e=%b s=%b want d=%0d e=%b s=%b", i, qd[i], qe[i], qs[i], xd[i], xe[i], xs[i]);
      end
    end
    n_run++;
    if (qc.size() == 0 || qc[0] - t0 !== LAT) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d", qc.size() == 0 ? -1 : qc[0] - t0, LAT);
    end
  endtask

  task automatic test_random;
    int h, p;
    do_reset;
    for (int i = 0; i < 12; i++) begin
      p = $urandom_range(74, 56);
      h = $urandom_range(p - 3, 3);
      period(h, p);
      expect_per(h, p);
    end
    pwm = 1'b1;
    tick(LAT + 3);
    n_run++;
    if (qd.size() != xd.size()) begin n_fail++; $display("FAIL random count: got %0d want %0d", qd.size(), xd.size()); end
    for (int i = 0; i < xd.size() && i < qd.size(); i++) begin
      n_run++;
      if (qd[i] !== xd[i] || qe[i] !== xe[i] || qs[i] !== xs[i]) begin
        n_fail++;
        $display("FAIL random pulse %0d: got d=%0d e=%b s=%b want d=%0d e=%b s=%b", i, qd[i], qe[i], qs[i], xd[i], xe[i], xs[i]);
      end
    end
  endtask

  task automatic test_timeout;
    do_reset;
    tick(300);
    expect_pulse(4'd0, 1'b1, 1'b1);
    n_run++;
    if (sin !== 1'b1) begin n_fail++; $display("FAIL timeout_low sin: got %b want 1", sin); end
    pwm = 1'b1;
    tick(LAT + 3);
    n_run++;
    if (sin !== 1'b0) begin n_fail++; $display("FAIL rise_clears sin: got %b want 0", sin); end
    tick(300);
    expect_pulse(4'd15, 1'b1, 1'b1);
    n_run++;
    if (sin !== 1'b1) begin n_fail++; $display("FAIL timeout_high sin: got %b want 1", sin); end
    pwm = 1'b0;
    tick(10);
    period(20, 64);
    expect_per(20, 64);
    n_run++;
    if (sin !== 1'b0) begin n_fail++; $display("FAIL rise_after_to sin: got %b want 0", sin); end
    pwm = 1'b1;
    tick(LAT + 3);
    n_run++;
    if (qd.size() != xd.size()) begin n_fail++; $display("FAIL timeout count: got %0d want %0d", qd.size(), xd.size()); end
    for (int i = 0; i < xd.size() && i < qd.size(); i++) begin
      n_run++;
      if (qd[i] !== xd[i] || qe[i] !== xe[i] || qs[i] !== xs[i]) begin
        n_fail++;
        $display("FAIL timeout pulse %0d: got d=%0d e=%b s=%b want d=%0d e=%b s=%b", i, qd[i], qe[i], qs[i], xd[i], xe[i], xs[i]);
      end
    end
  endtask

  task automatic test_enable_drop;
    do_reset;
    period(20, 64); expect_per(20, 64);
    period(30, 64); expect_per(30, 64);
    period(40, 70); expect_per(40, 70);
    pwm = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(20);
    n_run += 2;
    if (duty !== slots(40)) begin n_fail++; $display("FAIL enable_hold duty: got %0d want %0d", duty, slots(40)); end
    if (err !== bad(70)) begin n_fail++; $display("FAIL enable_hold err: got %b want %b", err, bad(70)); end
    pwm = 1'b0;
    tick(34);
    period(25, 64);
    enable = 1'b1;
    period(12, 64); expect_per(12, 64);
    period(50, 66); expect_per(50, 66);
    pwm = 1'b1;
    tick(LAT + 3);
    n_run++;
    if (qd.size() != xd.size()) begin n_fail++; $display("FAIL enable count: got %0d want %0d", qd.size(), xd.size()); end
    for (int i = 0; i < xd.size() && i < qd.size(); i++) begin
      n_run++;
      if (qd[i] !== xd[i] || qe[i] !== xe[i] || qs[i] !== xs[i]) begin
        n_fail++;
        $display("FAIL enable pulse %0d: got d=%0d e=%b s=%b want d=%0d e=%b s=%b", i, qd[i], qe[i], qs[i], xd[i], xe[i], xs[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    period(20, 64); expect_per(20, 64);
    period(36, 64); expect_per(36, 64);
    pwm = 1'b1;
    tick(10);
    rst = 1'b1;
    tick(2);
    n_run += 3;
    if (duty !== 4'd0) begin n_fail++; $display("FAIL rst_mid duty: got %0d want 0", duty); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_mid err: got %b want 0", err); end
    if (val !== 1'b0) begin n_fail++; $display("FAIL rst_mid valido: got %b want 0", val); end
    tick(8);
    pwm = 1'b0;
    tick(5);
    rst = 1'b0;
    tick(39);
    period(24, 64); expect_per(24, 64);
    period(44, 64); expect_per(44, 64);
    pwm = 1'b1;
    tick(LAT + 3);
    n_run++;
    if (qd.size() != xd.size()) begin n_fail++; $display("FAIL rst_mid count: got %0d want %0d", qd.size(), xd.size()); end
    for (int i = 0; i < xd.size() && i < qd.size(); i++) begin
      n_run++;
      if (qd[i] !== xd[i] || qe[i] !== xe[i] || qs[i] !== xs[i]) begin
        n_fail++;
        $display("FAIL rst_mid pulse %0d: got d=%0d e=%b s=%b want d=%0d e=%b s=%b", i, qd[i], qe[i], qs[i], xd[i], xe[i], xs[i]);
      end
    end
  endtask

  task automatic test_spikes;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      period(20, 40);
      period(2, 24);
      expect_per(20, 40);
      expect_per(2, 24);
    end
    pwm = 1'b1;
    tick(LAT + 3);
    n_run++;
    if (qd.size() != xd.size()) begin n_fail++; $display("FAIL spikes count: got %0d want %0d", qd.size(), xd.size()); end
    for (int i = 0; i < xd.size() && i < qd.size(); i++) begin
      n_run++;
      if (qd[i] !== xd[i] || qe[i] !== xe[i] || qs[i] !== xs[i]) begin
        n_fail++;
        $display("FAIL spikes pulse %0d: got d=%0d e=%b s=%b want d=%0d e=%b s=%b", i, qd[i], qe[i], qs[i], xd[i], xe[i], xs[i]);
      end
    end
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    rst = 1'b1;
    enable = 1'b1;
    pwm = 1'b0;
    test_reset;
    test_directed;
    test_random;
    test_timeout;
    test_enable_drop;
    test_reset_mid;
    test_spikes;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
